muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
Multi-cycle sequencer for the mult/div/mflo/mfhi operation class decoded by ALU control. Owns the HI/LO registers and runs an iterative signed shift-add multiply or restoring divide over WIDTH cycles. Raises a stall toward the pipeline while an operation is in flight or a HI/LO read would see stale data. Sits beside the single-cycle ALU in EX and is selected by the same 5-bit control code.

Parameters:
WIDTH, 32, operand and HI/LO width
CNT_W, $clog2(WIDTH), iteration counter width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
valid_i  in  1  EX-stage instruction valid
alu_ctrl_i  in  5  control code: 00111 mult, 01000 div, 01111 mflo, 10000 mfhi; all others ignored
op_a_i  in  WIDTH  rs value (multiplicand / dividend)
op_b_i  in  WIDTH  rt value (multiplier / divisor)
flush_i  in  1  abort in-flight op (exception/branch flush)
stall_o  in→out  1  hold EX and earlier stages this cycle
busy_o  out  1  operation in flight
result_o  out  WIDTH  LO for mflo, HI for mfhi; 0 otherwise
result_valid_o  out  1  mflo/mfhi completing this cycle
hi_o  out  WIDTH  HI register
lo_o  out  WIDTH  LO register

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous, active-low. On reset: state IDLE, HI=LO=0, counter=0, busy_o=0, stall_o=0, result_valid_o=0, result_o=0.
- States: IDLE, CALC, FIX.
- IDLE: valid_i && code∈{mult,div} → latch magnitudes |a|, |b|, result sign (a^b sign; for div, remainder sign = sign of a), counter=0 → CALC. Accept cycle: stall_o=0 (issuing instruction retires; op continues in background).
- CALC: one iteration/cycle; mult adds shifted multiplicand on multiplier bit; div is restoring shift-subtract. counter increments; after iteration WIDTH-1 → FIX. busy_o=1 in CALC and FIX.
- FIX: apply two's-complement sign correction; write HI/LO on this edge → IDLE. Latency: HI/LO valid WIDTH+1 cycles after accept edge (33 for WIDTH=32).
- mult: {HI,LO} = signed 2·WIDTH-bit product. div: LO = quotient truncated toward zero, HI = remainder with dividend's sign.
- Divide by zero: no error; HI = op_a_i, LO = all ones; still takes full latency.
- Most-negative / -1 divide: LO = most-negative, HI = 0 (natural wrap).
- stall_o = valid_i && busy_o && code∈{mult,div,mflo,mfhi}. Non-muldiv codes never stall.
- mflo/mfhi when !busy_o: result_o combinational from LO/HI, result_valid_o=1, same cycle.
- Mult/div issued in the FIX cycle: stalled one cycle, accepted next cycle in IDLE.
- flush_i: highest priority; any state → IDLE next edge, HI/LO unchanged, no accept that cycle, stall_o forced 0.
- Reset mid-operation: immediate return to reset values; partial result discarded.
- valid_i=0: no accept, no stall, no result_valid_o.

Optional Feature:
MULDIV_MTHILO_EN: when defined, codes 10100 (mthi) and 10101 (mtlo) write op_a_i into HI/LO at the next edge if !busy_o; they stall like mflo/mfhi while busy. Without the macro, those codes are ignored like any other non-muldiv code and HI/LO are written only by FIX.

Decomposition:
- Shared package muldiv_pkg: 5-bit code localparams (ALU_MULT, ALU_DIV, ALU_MFLO, ALU_MFHI, ALU_MTHI, ALU_MTLO), state enum typedef, WIDTH default.
- One natural sub-module, muldiv_iter_core: the per-iteration datapath (accumulator/remainder, shift, add/subtract) driven by a start and mode from the sequencer FSM; the top keeps FSM, sign fix, HI/LO, and stall logic.

Test Plan:
- mult a=7, b=-3 → busy_o for 33 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFEB; mflo returns 0xFFFFFFEB with result_valid_o=1.
- div a=-17, b=5 → LO=0xFFFFFFFD (-3), HI=0xFFFFFFFE (-2) after 33 cycles.
- mflo issued 2 cycles after mult accept → stall_o=1 until FIX completes, then result_o equals new LO in the first unstalled cycle.
- div a=0x12345678, b=0 → HI=0x12345678, LO=0xFFFFFFFF, no hang.
- flush_i pulsed at CALC cycle 10 with prior HI=0xAAAA, LO=0x5555 → IDLE next cycle, busy_o=0, HI/LO unchanged.
- rst_n low at CALC cycle 5 → all outputs 0 immediately (async), HI=LO=0; new mult 0x10000×0x10000 after release → HI=1, LO=0.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the mult/div/mflo/mfhi sequencer: ALU control codes,
// FSM state encoding and datapath mode.
package muldiv_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [4:0] ALU_MULT = 5'b00111;
  localparam logic [4:0] ALU_DIV  = 5'b01000;
  localparam logic [4:0] ALU_MFLO = 5'b01111;
  localparam logic [4:0] ALU_MFHI = 5'b10000;
  localparam logic [4:0] ALU_MTHI = 5'b10100;
  localparam logic [4:0] ALU_MTLO = 5'b10101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  typedef enum logic {
    MODE_MULT = 1'b0,
    MODE_DIV  = 1'b1
  } mode_t;

endpackage

// File: rtl/muldiv_iter_core.sv
// Iterative unsigned datapath: one shift-add multiply step or one restoring
// shift-subtract divide step per cycle on operand magnitudes. The {upper,lower}
// pair holds {partial product, multiplier} or {remainder, quotient}.
module muldiv_iter_core
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             step,
  input  mode_t            mode,
  input  logic [WIDTH-1:0] a_mag,
  input  logic [WIDTH-1:0] b_mag,
  output logic [WIDTH-1:0] upper,
  output logic [WIDTH-1:0] lower
);

  logic [WIDTH-1:0] acc_hi, acc_lo, operand;
  mode_t            mode_q;
  logic [WIDTH-1:0] nxt_hi, nxt_lo;
  logic [WIDTH:0]   sum, shifted;
  logic [WIDTH-1:0] diff;
  logic             ge;

  // Next value of the accumulator pair for one iteration of the latched mode.
  always_comb begin
    // NOTE: every output gets a value before any branch so no latch is inferred.
    nxt_hi  = acc_hi;
    nxt_lo  = acc_lo;
    sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
    shifted = {acc_hi, acc_lo[WIDTH-1]};
    ge      = shifted >= {1'b0, operand};
    // True difference is below the divisor whenever ge holds, so WIDTH bits suffice.
    diff    = shifted[WIDTH-1:0] - operand;
    if (mode_q == MODE_MULT) begin
      nxt_hi = sum[WIDTH:1];
      nxt_lo = {sum[0], acc_lo[WIDTH-1:1]};
    end else begin
      nxt_hi = ge ? diff : shifted[WIDTH-1:0];
      nxt_lo = {acc_lo[WIDTH-2:0], ge};
    end
  end

  // Load operands on start, advance one iteration on each step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: <= in clocked blocks so all flops update from pre-edge values.
      acc_hi  <= '0;
      acc_lo  <= '0;
      operand <= '0;
      mode_q  <= MODE_MULT;
    end else if (start) begin
      acc_hi  <= '0;
      acc_lo  <= (mode == MODE_MULT) ? b_mag : a_mag;
      operand <= (mode == MODE_MULT) ? a_mag : b_mag;
      mode_q  <= mode;
    end else if (step) begin
      acc_hi <= nxt_hi;
      acc_lo <= nxt_lo;
    end
  end

  assign upper = acc_hi;
  assign lower = acc_lo;

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle mult/div sequencer owning HI/LO, with pipeline stall generation.
// Optional build macro MULDIV_MTHILO_EN adds mthi/mtlo writes to HI/LO.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  input  logic [4:0]       alu_ctrl_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic [WIDTH-1:0] result_o,
  output logic             result_valid_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  logic is_mult, is_div, is_mflo, is_mfhi, is_mthi, is_mtlo, accept;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               busy_q, neg_q, neg_r, div_zero_q;
  mode_t              mode_q;
  logic [WIDTH-1:0]   hi_q, lo_q, a_mag, b_mag, core_hi, core_lo, hi_fix, lo_fix;
  logic [2*WIDTH-1:0] prod_mag, prod_fix;

  assign is_mult = (alu_ctrl_i == ALU_MULT);
  assign is_div  = (alu_ctrl_i == ALU_DIV);
  assign is_mflo = (alu_ctrl_i == ALU_MFLO);
  assign is_mfhi = (alu_ctrl_i == ALU_MFHI);
`ifdef MULDIV_MTHILO_EN
  assign is_mthi = (alu_ctrl_i == ALU_MTHI);
  assign is_mtlo = (alu_ctrl_i == ALU_MTLO);
`else
  assign is_mthi = 1'b0;
  assign is_mtlo = 1'b0;
`endif

  assign accept = valid_i && !flush_i && (state == ST_IDLE) && (is_mult || is_div);
  assign a_mag  = op_a_i[WIDTH-1] ? -op_a_i : op_a_i;
  assign b_mag  = op_b_i[WIDTH-1] ? -op_b_i : op_b_i;

  muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .start (accept),
    .step  (state == ST_CALC),
    .mode  (is_div ? MODE_DIV : MODE_MULT),
    .a_mag (a_mag),
    .b_mag (b_mag),
    .upper (core_hi),
    .lower (core_lo)
  );

  // Two's-complement sign correction of the magnitude result for HI/LO.
  always_comb begin
    prod_mag = {core_hi, core_lo};
    prod_fix = neg_q ? -prod_mag : prod_mag;
    hi_fix   = prod_fix[2*WIDTH-1:WIDTH];
    lo_fix   = prod_fix[WIDTH-1:0];
    if (mode_q == MODE_DIV) begin
      // Divide by zero leaves the quotient all ones regardless of sign.
      lo_fix = div_zero_q ? '1 : (neg_q ? -core_lo : core_lo);
      hi_fix = neg_r ? -core_hi : core_hi;
    end
  end

  // Sequencer FSM: accept, iterate WIDTH times, then sign-fix into HI/LO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      busy_q     <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      mode_q     <= MODE_MULT;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      div_zero_q <= 1'b0;
    end else if (flush_i) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      busy_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state      <= ST_CALC;
            cnt        <= '0;
            busy_q     <= 1'b1;
            mode_q     <= is_div ? MODE_DIV : MODE_MULT;
            neg_q      <= op_a_i[WIDTH-1] ^ op_b_i[WIDTH-1];
            neg_r      <= op_a_i[WIDTH-1];
            div_zero_q <= (op_b_i == '0);
          end else if (valid_i && is_mthi) begin
            hi_q <= op_a_i;
          end else if (valid_i && is_mtlo) begin
            lo_q <= op_a_i;
          end
        end
        ST_CALC: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST_ITER) state <= ST_FIX;
        end
        ST_FIX: begin
          hi_q   <= hi_fix;
          lo_q   <= lo_fix;
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o         = busy_q;
  assign stall_o        = valid_i && busy_q && !flush_i &&
                          (is_mult || is_div || is_mflo || is_mfhi || is_mthi || is_mtlo);
  assign result_valid_o = valid_i && !busy_q && (is_mflo || is_mfhi);
  assign result_o       = !result_valid_o ? '0 : (is_mflo ? lo_q : hi_q);
  assign hi_o           = hi_q;
  assign lo_o           = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer (default build, WIDTH=32).
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        valid_i = 1'b0;
  logic [4:0]  alu_ctrl_i = '0;
  logic [31:0] op_a_i = '0, op_b_i = '0;
  logic        flush_i = 1'b0;
  logic        stall_o, busy_o, result_valid_o;
  logic [31:0] result_o, hi_o, lo_o;

  int n_cmp = 0;
  int n_fail = 0;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .valid_i        (valid_i),
    .alu_ctrl_i     (alu_ctrl_i),
    .op_a_i         (op_a_i),
    .op_b_i         (op_b_i),
    .flush_i        (flush_i),
    .stall_o        (stall_o),
    .busy_o         (busy_o),
    .result_o       (result_o),
    .result_valid_o (result_valid_o),
    .hi_o           (hi_o),
    .lo_o           (lo_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  code;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: signed 64-bit arithmetic straight from the mult/div rules.
  function automatic logic [63:0] model(input logic [4:0] code, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, p, q, r;
    logic [63:0] pv, qv, rv;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (code == ALU_MULT) begin
      p  = sa * sb;
      pv = p;
      return pv;
    end
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    q  = sa / sb;
    r  = sa % sb;
    qv = q;
    rv = r;
    return {rv[31:0], qv[31:0]};
  endfunction

  // Present a mult/div for one cycle; returns at the first negedge after accept.
  task automatic issue(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b,
                       input string name);
    @(negedge clk);
    valid_i = 1'b1; alu_ctrl_i = code; op_a_i = a; op_b_i = b;
    #1 check({name, " accept stall"}, {31'd0, stall_o}, 32'd0);
    @(negedge clk);
    valid_i = 1'b0; alu_ctrl_i = '0;
  endtask

  // Count busy cycles, bounded so a stuck FSM cannot hang the run.
  task automatic wait_done(input string name);
    int cycles = 0;
    while (busy_o === 1'b1 && cycles < 200) begin
      cycles++;
      @(negedge clk);
    end
    check({name, " busy cycles"}, cycles, 33);
  endtask

  task automatic read_reg(input logic [4:0] code, input logic [31:0] exp, input string name);
    @(negedge clk);
    valid_i = 1'b1; alu_ctrl_i = code;
    #1;
    check({name, " result_valid"}, {31'd0, result_valid_o}, 32'd1);
    check({name, " result"}, result_o, exp);
    valid_i = 1'b0; alu_ctrl_i = '0;
  endtask

  task automatic run_op(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo, input string name);
    issue(code, a, b, name);
    wait_done(name);
    check({name, " hi"}, hi_o, exp_hi);
    check({name, " lo"}, lo_o, exp_lo);
    read_reg(ALU_MFLO, exp_lo, {name, " mflo"});
    read_reg(ALU_MFHI, exp_hi, {name, " mfhi"});
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, " busy"}, {31'd0, busy_o}, 32'd0);
    check({name, " stall"}, {31'd0, stall_o}, 32'd0);
    check({name, " result_valid"}, {31'd0, result_valid_o}, 32'd0);
    check({name, " result"}, result_o, 32'd0);
    check({name, " hi"}, hi_o, 32'd0);
    check({name, " lo"}, lo_o, 32'd0);
  endtask

  initial begin
    vec_t vecs[10];
    logic [63:0] m;
    logic [4:0]  rc;
    logic [31:0] ra, rb;
    int          stalled;

    vecs[0] = '{ALU_MULT, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[1] = '{ALU_DIV,  32'hFFFF_FFEF,  32'd5,         32'hFFFF_FFFE, 32'hFFFF_FFFD};
    vecs[2] = '{ALU_DIV,  32'h1234_5678,  32'd0,         32'h1234_5678, 32'hFFFF_FFFF};
    vecs[3] = '{ALU_DIV,  32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[4] = '{ALU_MULT, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[5] = '{ALU_DIV,  32'd100,        32'd7,         32'd2,         32'd14};
    vecs[6] = '{ALU_MULT, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd0,         32'd1};
    vecs[7] = '{ALU_DIV,  32'h8000_0000,  32'd0,         32'h8000_0000, 32'hFFFF_FFFF};
    vecs[8] = '{ALU_DIV,  32'd7,          32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
    vecs[9] = '{ALU_MULT, 32'h1234_5678,  32'd0,         32'd0,         32'd0};

    // Reset state.
    #1 rst_n = 1'b0;
    #1 check_idle_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors.
    for (int i = 0; i < 10; i++)
      run_op(vecs[i].code, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo,
             $sformatf("vec%0d", i));

    // mflo issued two cycles after accept stalls until FIX has written LO.
    issue(ALU_MULT, 32'd7, 32'd9, "mflo_stall");
    @(negedge clk);
    valid_i = 1'b1; alu_ctrl_i = ALU_MFLO;
    stalled = 0;
    #1;
    while (stall_o === 1'b1 && stalled < 100) begin
      stalled++;
      @(negedge clk);
      #1;
    end
    check("mflo_stall cycles", stalled, 32);
    check("mflo_stall result_valid", {31'd0, result_valid_o}, 32'd1);
    check("mflo_stall result", result_o, 32'd63);
    valid_i = 1'b0; alu_ctrl_i = '0;

    // mult presented during FIX is held one cycle, then accepted in IDLE.
    issue(ALU_MULT, 32'd11, 32'd13, "fix_issue_a");
    repeat (32) @(negedge clk);
    valid_i = 1'b1; alu_ctrl_i = ALU_MULT; op_a_i = 32'hFFFF_FFFB; op_b_i = 32'd6;
    #1;
    check("fix_issue stall in FIX", {31'd0, stall_o}, 32'd1);
    @(negedge clk);
    #1;
    check("fix_issue stall after", {31'd0, stall_o}, 32'd0);
    check("fix_issue lo of first", lo_o, 32'd143);
    @(negedge clk);
    valid_i = 1'b0; alu_ctrl_i = '0;
    wait_done("fix_issue_b");
    check("fix_issue_b hi", hi_o, 32'hFFFF_FFFF);
    check("fix_issue_b lo", lo_o, 32'hFFFF_FFE2);

    // Flush at CALC cycle 10 leaves HI/LO untouched.
    run_op(ALU_DIV, 32'h5555_AAAA, 32'h0001_0000, 32'h0000_AAAA, 32'h0000_5555, "flush_pre");
    issue(ALU_MULT, 32'd3, 32'd5, "flush");
    repeat (4) @(negedge clk);
    valid_i = 1'b1; alu_ctrl_i = 5'b00000;
    #1 check("non-muldiv stall", {31'd0, stall_o}, 32'd0);
    alu_ctrl_i = ALU_MTHI;
    #1 check("mthi code stall", {31'd0, stall_o}, 32'd0);
    valid_i = 1'b0; alu_ctrl_i = ALU_MFLO;
    #1 check("mflo invalid stall", {31'd0, stall_o}, 32'd0);
    repeat (6) @(negedge clk);
    valid_i = 1'b1; alu_ctrl_i = ALU_MFLO; flush_i = 1'b1;
    #1 check("flush forces stall low", {31'd0, stall_o}, 32'd0);
    @(negedge clk);
    valid_i = 1'b0; alu_ctrl_i = '0; flush_i = 1'b0;
    #1;
    check("flush busy", {31'd0, busy_o}, 32'd0);
    check("flush hi", hi_o, 32'h0000_AAAA);
    check("flush lo", lo_o, 32'h0000_5555);
    repeat (40) @(negedge clk);
    check("flush hi later", hi_o, 32'h0000_AAAA);
    check("flush lo later", lo_o, 32'h0000_5555);
    read_reg(ALU_MFLO, 32'h0000_5555, "flush mflo");

    // Asynchronous reset at CALC cycle 5 discards the op and clears HI/LO.
    issue(ALU_MULT, 32'd1234, 32'd5678, "rst_mid");
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1 check_idle_outputs("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    run_op(ALU_MULT, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0, "after_rst");

    // Randomized ops against the arithmetic model.
    for (int i = 0; i < 24; i++) begin
      rc = ($urandom_range(0, 1) == 0) ? ALU_MULT : ALU_DIV;
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(0, 15) - 8;
        default: rb = $urandom;
      endcase
      m = model(rc, ra, rb);
      run_op(rc, ra, rb, m[63:32], m[31:0], $sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
